wb_stage_gen: RTL and testbench

WB_STAGE_GEN -- requirements
Module: wb_stage_gen

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_load_ext.sv | 51 +++++
 rtl/wb_stage_gen.sv | 140 ++++++++++++++
 tb/tb_wb_stage_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg -- shared definitions for the write-back stage.
//   * default datapath / register-index / tag widths
//   * load-mode encodings carried on mem_ldmode (5..7 are reserved)
//   * small helpers that classify a load mode
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_RA_W   = 5;
  localparam int WB_TAG_W  = 4;

  typedef enum logic [2:0] {
    LD_WORD   = 3'd0,
    LD_BYTE_S = 3'd1,
    LD_BYTE_U = 3'd2,
    LD_HALF_S = 3'd3,
    LD_HALF_U = 3'd4
  } ld_mode_e;

  function automatic logic is_half(input logic [2:0] mode);
    return (mode == LD_HALF_S) || (mode == LD_HALF_U);
  endfunction

  function automatic logic is_word(input logic [2:0] mode);
    return (mode == LD_WORD);
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext -- combinational load lane select and sign/zero extension.
// Ports:
//   mdata    in   raw memory word
//   ldmode   in   load mode (wb_pkg::ld_mode_e; 5..7 reserved -> pass-through)
//   addr_lo  in   byte offset of the access
//   ldata    out  extended load result
//   mis_raw  out  offset is illegal for the mode (not yet qualified by valid/m2reg)
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [DATA_W-1:0] mdata,
  input  logic [2:0]        ldmode,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] ldata,
  output logic              mis_raw
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lanes always come from the low 32 bits, even for wider datapaths.
  always_comb begin
    byte_lane = mdata[7:0];
    case (addr_lo)
      2'd0: byte_lane = mdata[7:0];
      2'd1: byte_lane = mdata[15:8];
      2'd2: byte_lane = mdata[23:16];
      2'd3: byte_lane = mdata[31:24];
      default: byte_lane = mdata[7:0];
    endcase
    half_lane = addr_lo[1] ? mdata[31:16] : mdata[15:0];
  end

  always_comb begin
    ldata = mdata;
    case (ldmode)
      LD_BYTE_S: ldata = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      LD_BYTE_U: ldata = {{(DATA_W-8){1'b0}}, byte_lane};
      LD_HALF_S: ldata = {{(DATA_W-16){half_lane[15]}}, half_lane};
      LD_HALF_U: ldata = {{(DATA_W-16){1'b0}}, half_lane};
      default:   ldata = mdata;  // word and reserved modes pass through
    endcase
  end

  // Bytes are never misaligned; reserved modes are not flagged either.
  assign mis_raw = (is_half(ldmode) && addr_lo[0]) ||
                   (is_word(ldmode) && (addr_lo != 2'd0));

endmodule

// File: rtl/wb_stage_gen.sv
// wb_stage_gen -- pipeline write-back stage register with retire tracking.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_*                    instruction from MEM (valid, dest, ALU result,
//                            raw load word, write enable, load select, mode,
//                            byte offset)
//   MEM_ins_type/number      debug tags, registered to WB_ins_type/number
//   wb_stall, wb_flush       hold the WB register / kill the incoming slot
//   mem_ready                WB accepts this cycle (= !wb_stall)
//   wb_valid/wreg/destR/dest register-file write port
//   wb_misalign              live load has an illegal offset
//   wb_last_*                most recently retired register write (bypass)
//   wb_retire_cnt            free-running retired-instruction count
module wb_stage_gen
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int RA_W   = WB_RA_W,
  parameter int TAG_W  = WB_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [RA_W-1:0]   mem_destR,
  input  logic [DATA_W-1:0] mem_aluR,
  input  logic [DATA_W-1:0] mem_mdata,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  input  logic [2:0]        mem_ldmode,
  input  logic [1:0]        mem_addr_lo,
  input  logic [TAG_W-1:0]  MEM_ins_type,
  input  logic [TAG_W-1:0]  MEM_ins_number,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic              mem_ready,
  output logic              wb_valid,
  output logic              wb_wreg,
  output logic [RA_W-1:0]   wb_destR,
  output logic [DATA_W-1:0] wb_dest,
  output logic [TAG_W-1:0]  WB_ins_type,
  output logic [TAG_W-1:0]  WB_ins_number,
  output logic              wb_misalign,
  output logic              wb_last_wreg,
  output logic [RA_W-1:0]   wb_last_destR,
  output logic [DATA_W-1:0] wb_last_dest,
  output logic [31:0]       wb_retire_cnt
);

  logic              valid_reg;
  logic [RA_W-1:0]   destr_reg;
  logic [DATA_W-1:0] alur_reg;
  logic [DATA_W-1:0] mdata_reg;
  logic              wreg_reg;
  logic              m2reg_reg;
  logic [2:0]        ldmode_reg;
  logic [1:0]        addr_lo_reg;
  logic [TAG_W-1:0]  ins_type_reg;
  logic [TAG_W-1:0]  ins_number_reg;
  logic              last_wreg_reg;
  logic [RA_W-1:0]   last_destr_reg;
  logic [DATA_W-1:0] last_dest_reg;
  logic [31:0]       retire_cnt_reg;

  logic [DATA_W-1:0] load_data;
  logic              mis_raw;
  logic              retire;

  wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .mdata   (mdata_reg),
    .ldmode  (ldmode_reg),
    .addr_lo (addr_lo_reg),
    .ldata   (load_data),
    .mis_raw (mis_raw)
  );

  assign mem_ready   = !wb_stall;
  assign wb_misalign = valid_reg && m2reg_reg && mis_raw;
  assign wb_wreg     = valid_reg && wreg_reg && (destr_reg != '0) && !wb_misalign;
  assign wb_dest     = m2reg_reg ? load_data : alur_reg;
  // A flushed slot never retires, even if it was not stalled.
  assign retire      = valid_reg && !wb_stall && !wb_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg      <= 1'b0;
      destr_reg      <= '0;
      alur_reg       <= '0;
      mdata_reg      <= '0;
      wreg_reg       <= 1'b0;
      m2reg_reg      <= 1'b0;
      ldmode_reg     <= 3'd0;
      addr_lo_reg    <= 2'd0;
      ins_type_reg   <= '0;
      ins_number_reg <= '0;
      last_wreg_reg  <= 1'b0;
      last_destr_reg <= '0;
      last_dest_reg  <= '0;
      retire_cnt_reg <= 32'd0;
    end else begin
      // Flush wins over stall for the valid bit; payload follows stall only.
      if (wb_flush) begin
        valid_reg <= 1'b0;
      end else if (!wb_stall) begin
        valid_reg <= mem_valid;
      end

      if (!wb_stall) begin
        destr_reg      <= mem_destR;
        alur_reg       <= mem_aluR;
        mdata_reg      <= mem_mdata;
        wreg_reg       <= mem_wreg;
        m2reg_reg      <= mem_m2reg;
        ldmode_reg     <= mem_ldmode;
        addr_lo_reg    <= mem_addr_lo;
        ins_type_reg   <= MEM_ins_type;
        ins_number_reg <= MEM_ins_number;
      end

      if (retire) begin
        retire_cnt_reg <= retire_cnt_reg + 32'd1;
        last_wreg_reg  <= wb_wreg;
        // Bypass data only tracks instructions that really wrote a register.
        if (wb_wreg) begin
          last_destr_reg <= destr_reg;
          last_dest_reg  <= wb_dest;
        end
      end
    end
  end

  assign wb_valid      = valid_reg;
  assign wb_destR      = destr_reg;
  assign WB_ins_type   = ins_type_reg;
  assign WB_ins_number = ins_number_reg;
  assign wb_last_wreg  = last_wreg_reg;
  assign wb_last_destR = last_destr_reg;
  assign wb_last_dest  = last_dest_reg;
  assign wb_retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_wb_stage_gen.sv
// tb_wb_stage_gen -- directed bench for wb_stage_gen.
// Inputs change on the falling edge; outputs are sampled on the following
// falling edge, half a period after the capturing rising edge.
module tb_wb_stage_gen;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_destR;
  logic [31:0] mem_aluR;
  logic [31:0] mem_mdata;
  logic        mem_wreg;
  logic        mem_m2reg;
  logic [2:0]  mem_ldmode;
  logic [1:0]  mem_addr_lo;
  logic [3:0]  MEM_ins_type;
  logic [3:0]  MEM_ins_number;
  logic        wb_stall;
  logic        wb_flush;
  logic        mem_ready;
  logic        wb_valid;
  logic        wb_wreg;
  logic [4:0]  wb_destR;
  logic [31:0] wb_dest;
  logic [3:0]  WB_ins_type;
  logic [3:0]  WB_ins_number;
  logic        wb_misalign;
  logic        wb_last_wreg;
  logic [4:0]  wb_last_destR;
  logic [31:0] wb_last_dest;
  logic [31:0] wb_retire_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  wb_stage_gen dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_destR      (mem_destR),
    .mem_aluR       (mem_aluR),
    .mem_mdata      (mem_mdata),
    .mem_wreg       (mem_wreg),
    .mem_m2reg      (mem_m2reg),
    .mem_ldmode     (mem_ldmode),
    .mem_addr_lo    (mem_addr_lo),
    .MEM_ins_type   (MEM_ins_type),
    .MEM_ins_number (MEM_ins_number),
    .wb_stall       (wb_stall),
    .wb_flush       (wb_flush),
    .mem_ready      (mem_ready),
    .wb_valid       (wb_valid),
    .wb_wreg        (wb_wreg),
    .wb_destR       (wb_destR),
    .wb_dest        (wb_dest),
    .WB_ins_type    (WB_ins_type),
    .WB_ins_number  (WB_ins_number),
    .wb_misalign    (wb_misalign),
    .wb_last_wreg   (wb_last_wreg),
    .wb_last_destR  (wb_last_destR),
    .wb_last_dest   (wb_last_dest),
    .wb_retire_cnt  (wb_retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_in(input logic v, input logic [4:0] dr, input logic [31:0] alu,
                        input logic [31:0] md, input logic wr, input logic m2,
                        input logic [2:0] mode, input logic [1:0] lo);
    mem_valid   = v;
    mem_destR   = dr;
    mem_aluR    = alu;
    mem_mdata   = md;
    mem_wreg    = wr;
    mem_m2reg   = m2;
    mem_ldmode  = mode;
    mem_addr_lo = lo;
  endtask

  // One clock; prints one line describing the WB state afterwards.
  task automatic tick();
    @(negedge clk);
    cycle++;
    $display("cyc %0d: stall=%0b flush=%0b -> valid=%0b destR=%0d dest=0x%08h wreg=%0b mis=%0b cnt=%0d",
             cycle, wb_stall, wb_flush, wb_valid, wb_destR, wb_dest, wb_wreg, wb_misalign, wb_retire_cnt);
  endtask

  // Load-extension vectors: mode, offset, raw word, expected data, misalign.
  logic [2:0]  lt_mode [6] = '{3'd2, 3'd3, 3'd0, 3'd0, 3'd6, 3'd1};
  logic [1:0]  lt_lo   [6] = '{2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd0};
  logic [31:0] lt_md   [6] = '{32'h0000_F200, 32'h8001_0000, 32'hCAFE_BABE,
                               32'h1122_3344, 32'h5566_7788, 32'h0000_007F};
  logic [31:0] lt_exp  [6] = '{32'h0000_00F2, 32'hFFFF_8001, 32'hCAFE_BABE,
                               32'h1122_3344, 32'h5566_7788, 32'h0000_007F};
  logic        lt_mis  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    MEM_ins_type = 4'd0;
    MEM_ins_number = 4'd0;
    mem_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
    tick();
    tick();
    check("rst_valid", wb_valid, 0);
    check("rst_dest", wb_dest, 0);
    check("rst_cnt", wb_retire_cnt, 0);
    check("rst_last_wreg", wb_last_wreg, 0);
    rst = 1'b0;

    // T1: signed byte from lane 3
    mem_in(1'b1, 5'd3, 32'd0, 32'h80FF_1234, 1'b1, 1'b1, 3'd1, 2'd3);
    MEM_ins_type = 4'hA;
    MEM_ins_number = 4'h5;
    #1 check("ready_idle", mem_ready, 1);
    tick();
    check("lb_dest", wb_dest, 32'hFFFF_FF80);
    check("lb_wreg", wb_wreg, 1);
    check("lb_destR", wb_destR, 3);
    check("lb_tag_type", WB_ins_type, 4'hA);
    check("lb_tag_num", WB_ins_number, 4'h5);
    check("lb_cnt", wb_retire_cnt, 0);

    // T2: unsigned half, upper lane
    mem_in(1'b1, 5'd4, 32'd0, 32'hBEEF_0001, 1'b1, 1'b1, 3'd4, 2'd2);
    tick();
    check("lhu_dest", wb_dest, 32'h0000_BEEF);
    check("lhu_cnt", wb_retire_cnt, 1);
    check("lhu_last_wreg", wb_last_wreg, 1);
    check("lhu_last_destR", wb_last_destR, 3);
    check("lhu_last_dest", wb_last_dest, 32'hFFFF_FF80);

    // T3: misaligned signed half
    mem_in(1'b1, 5'd6, 32'd0, 32'h0000_8000, 1'b1, 1'b1, 3'd3, 2'd1);
    tick();
    check("lh_mis", wb_misalign, 1);
    check("lh_mis_wreg", wb_wreg, 0);
    check("lh_mis_cnt", wb_retire_cnt, 2);
    check("lh_last_destR", wb_last_destR, 4);
    check("lh_last_dest", wb_last_dest, 32'h0000_BEEF);

    // T4: ALU write to x0
    mem_in(1'b1, 5'd0, 32'd5, 32'd0, 1'b1, 1'b0, 3'd0, 2'd0);
    tick();
    check("x0_wreg", wb_wreg, 0);
    check("x0_dest", wb_dest, 5);
    check("x0_cnt", wb_retire_cnt, 3);
    check("mis_last_wreg", wb_last_wreg, 0);
    check("mis_last_destR_hold", wb_last_destR, 4);

    // T5: ordinary ALU write
    mem_in(1'b1, 5'd7, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 3'd0, 2'd0);
    tick();
    check("alu_dest", wb_dest, 32'h1234_5678);
    check("alu_cnt", wb_retire_cnt, 4);
    check("x0_last_wreg", wb_last_wreg, 0);
    check("x0_last_dest_hold", wb_last_dest, 32'h0000_BEEF);

    // Stall 3 cycles while MEM offers new data
    wb_stall = 1'b1;
    mem_in(1'b1, 5'd9, 32'h0000_AAAA, 32'd0, 1'b1, 1'b0, 3'd0, 2'd0);
    #1 check("ready_stall", mem_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_dest", wb_dest, 32'h1234_5678);
      check("stall_destR", wb_destR, 7);
      check("stall_cnt", wb_retire_cnt, 4);
      check("stall_valid", wb_valid, 1);
    end
    wb_stall = 1'b0;
    tick();
    check("unstall_cnt", wb_retire_cnt, 5);
    check("unstall_dest", wb_dest, 32'h0000_AAAA);
    check("unstall_last_destR", wb_last_destR, 7);
    check("unstall_last_dest", wb_last_dest, 32'h1234_5678);
    check("unstall_last_wreg", wb_last_wreg, 1);

    // Load-extension table, destR=1, wreg=1
    for (int i = 0; i < 6; i++) begin
      mem_in(1'b1, 5'd1, 32'hDEAD_0000, lt_md[i], 1'b1, 1'b1, lt_mode[i], lt_lo[i]);
      tick();
      check($sformatf("ld%0d_dest", i), wb_dest, lt_exp[i]);
      check($sformatf("ld%0d_mis", i), wb_misalign, lt_mis[i]);
      check($sformatf("ld%0d_wreg", i), wb_wreg, !lt_mis[i]);
    end
    check("tbl_cnt", wb_retire_cnt, 11);
    check("tbl_last_dest", wb_last_dest, 32'h5566_7788);

    // Flush alone: incoming killed, held instruction not counted
    wb_flush = 1'b1;
    mem_in(1'b1, 5'd2, 32'h99, 32'd0, 1'b1, 1'b0, 3'd0, 2'd0);
    tick();
    wb_flush = 1'b0;
    check("flush_valid", wb_valid, 0);
    check("flush_wreg", wb_wreg, 0);
    check("flush_cnt", wb_retire_cnt, 11);
    check("flush_last_dest", wb_last_dest, 32'h5566_7788);

    mem_in(1'b1, 5'd3, 32'h77, 32'd0, 1'b1, 1'b0, 3'd0, 2'd0);
    tick();
    check("post_flush_cnt", wb_retire_cnt, 11);
    check("post_flush_valid", wb_valid, 1);

    // Counter wrap: preload all-ones, then one retire
    mem_in(1'b1, 5'd5, 32'h33, 32'd0, 1'b1, 1'b0, 3'd0, 2'd0);
    force dut.retire_cnt_reg = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_reg;
    #1 check("preload_cnt", wb_retire_cnt, 32'hFFFF_FFFF);
    tick();
    check("wrap_cnt", wb_retire_cnt, 0);
    check("wrap_last_destR", wb_last_destR, 3);
    check("wrap_last_dest", wb_last_dest, 32'h77);

    // Stall and flush together
    wb_stall = 1'b1;
    wb_flush = 1'b1;
    mem_in(1'b1, 5'd8, 32'h88, 32'd0, 1'b1, 1'b0, 3'd0, 2'd0);
    tick();
    check("sf_valid", wb_valid, 0);
    check("sf_cnt", wb_retire_cnt, 0);
    check("sf_destR_hold", wb_destR, 5);
    check("sf_wreg", wb_wreg, 0);
    wb_stall = 1'b0;
    wb_flush = 1'b0;

    mem_in(1'b1, 5'd6, 32'h44, 32'd0, 1'b1, 1'b0, 3'd0, 2'd0);
    tick();
    check("pre_rst_valid", wb_valid, 1);
    check("pre_rst_cnt", wb_retire_cnt, 0);

    // Reset overrides stall; live instruction discarded
    rst = 1'b1;
    wb_stall = 1'b1;
    tick();
    check("rst2_valid", wb_valid, 0);
    check("rst2_dest", wb_dest, 0);
    check("rst2_destR", wb_destR, 0);
    check("rst2_cnt", wb_retire_cnt, 0);
    check("rst2_last_dest", wb_last_dest, 0);
    check("rst2_tag", WB_ins_type, 0);
    rst = 1'b0;
    wb_stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
